rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
//   Registered round-robin arbiter for 16 requesters. Produces a one-hot
//   16-bit grant vector plus a grant-valid flag. It sits directly upstream of
//   the 16-to-4 encoder: grant drives encoder_in and grant_valid drives enable,
//   yielding the 4-bit index of the current owner. A grant lasts while the
//   owner keeps requesting, bounded by MAX_HOLD when other requesters wait.
// PARAMETERS
//   N         16  number of requesters; fixed at 16 to match the encoder input
//   MAX_HOLD  8   max consecutive grant cycles while others wait; 0 = unlimited
// PORTS
//   clk          input   1   single clock; all state updates on rising edge
//   reset        input   1   synchronous, active-high reset
//   req          input   16  request lines; bit i = requester i, level-sensitive
//   grant        output  16  registered one-hot grant; all-zero when idle
//   grant_valid  output  1   registered; equals |grant
// BEHAVIOUR
//   - Reset is synchronous and active-high. On reset: grant=0, grant_valid=0,
//     state=IDLE, ptr=15 so index 0 has first priority, and hold_cnt=0.
//     Reset overrides everything, including mid-grant.
//   - ptr (4b) holds the index of the last or current owner.
//     hold_cnt counts cycles the owner has held the grant; width is
//     $clog2(MAX_HOLD+1), with a minimum of 1 bit.
//   - Winner search: first set bit of the candidate mask, scanning from ptr+1
//     upward and wrapping 15->0 (mod 16). The scan ends at ptr itself.
//   - States: IDLE and GRANT.
//   - IDLE: if req != 0, then on the next edge grant <= onehot(winner of req),
//     ptr <= winner, hold_cnt <= 1, and state becomes GRANT. Otherwise stay.
//   - GRANT (owner h = ptr), evaluated in priority order each edge:
//       1. req[h]==0 (release): if req!=0, switch to winner of req with
//          hold_cnt<=1 and no idle bubble. Otherwise grant<=0 and state IDLE.
//       2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req & ~onehot(h))!=0: preempt.
//          Grant the winner of (req & ~onehot(h)) and set hold_cnt<=1.
//       3. Otherwise hold the grant. hold_cnt increments and saturates at
//          MAX_HOLD. A sole requester is never preempted.
//   - Latency: a request seen at edge k produces its grant after edge k.
//     The grant drops or moves one edge after the release or timeout condition.
//   - Invariant: grant is always one-hot or zero. It never has more than one
//     bit set, and never shows an X after reset.
//   - Simultaneous release and timeout: release (rule 1) wins. The result
//     is the same winner either way.
//   - Fairness: with all 16 requesting continuously, each gets MAX_HOLD
//     cycles in order 0,1,...,15,0. Maximum wait is 15*MAX_HOLD cycles.
//   - Requests arriving mid-grant never preempt before MAX_HOLD is reached.
//   - The block never reads or depends on encoder output.
// TESTING
//   1. reset; req=16'h0001 -> after 1 edge grant=16'h0001, grant_valid=1.
//   2. MAX_HOLD=4, req=16'h8001 held -> grant 0x0001 x4 cycles,
//      then 0x8000 x4, then 0x0001, repeating.
//   3. req=16'h0012 -> grant=0x0002. Drop bit1 (req=0x0010)
//      -> next edge grant=0x0010 with no zero cycle.
//   4. Wrap: owner 14 (0x4000) releases while req=16'h0005
//      -> grant=0x0001 (scan 15,0).
//   5. Sole requester req=16'h0100 for 20 cycles -> grant=0x0100 every cycle.
//      Then req=0 -> grant=0, valid=0.
//   6. reset asserted mid-grant -> grant=0 next edge. Then req=16'h8001
//      -> grant=0x0001. Check one-hot/zero invariant on every cycle.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Registered round-robin arbiter for 16 requesters with a bounded hold time.
// Grant is one-hot or zero; grant_valid mirrors |grant as a registered flag.
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int HW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            any_found, oth_found;
  logic [3:0]      any_idx, oth_idx;

  // Scan from p+1 upward, wrapping mod 16; the last candidate examined is p.
  function automatic logic [4:0] find_winner(input logic [N-1:0] mask,
                                             input logic [3:0]   p);
    logic       found;
    logic [3:0] idx;
    logic [3:0] c;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 16; i++) begin
      c = p + 4'(i);
      if (!found && mask[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [3:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    {any_found, any_idx} = find_winner(req, ptr_q);
    {oth_found, oth_idx} = find_winner(req & ~onehot(ptr_q), ptr_q);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (any_found) begin
          grant_d = onehot(any_idx);
          ptr_d   = any_idx;
          hold_d  = HW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[ptr_q]) begin
          if (any_found) begin
            grant_d = onehot(any_idx);
            ptr_d   = any_idx;
            hold_d  = HW'(1);
          end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD) && oth_found) begin
          grant_d = onehot(oth_idx);
          ptr_d   = oth_idx;
          hold_d  = HW'(1);
        end else if (MAX_HOLD != 0 && hold_q < HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 4'd15;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with MAX_HOLD=4; expectations are hand-computed.
module tb_rr_arbiter16;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] grant;
  logic        grant_valid;

  int unsigned total;
  int unsigned bad;

  rr_arbiter16 #(.N(16), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (grant === exp) else begin
      bad++;
      $error("FAIL %s grant=%h expected=%h", tag, grant, exp);
    end
    total++;
    assert (grant_valid === (exp != 16'h0)) else begin
      bad++;
      $error("FAIL %s_valid grant_valid=%b expected=%b", tag, grant_valid, (exp != 16'h0));
    end
    total++;
    assert ($onehot0(grant) === 1'b1) else begin
      bad++;
      $error("FAIL %s_onehot grant=%h expected one-hot or zero", tag, grant);
    end
  endtask

  task automatic step(input logic [15:0] r, input string tag, input logic [15:0] exp);
    req = r;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = '0;
    @(posedge clk);
    #1;
    chk("reset", 16'h0000);
    reset = 1'b0;

    // 1: single request granted after one edge
    step(16'h0001, "t1_grant", 16'h0001);

    // 2: two requesters alternate every MAX_HOLD cycles
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) step(16'h8001, "t2_own0", 16'h0001);
      for (int k = 0; k < 4; k++) step(16'h8001, "t2_own15", 16'h8000);
    end
    step(16'h8001, "t2_back0", 16'h0001);

    // 3: release hands over without an idle cycle
    do_reset();
    step(16'h0012, "t3_first", 16'h0002);
    step(16'h0010, "t3_handoff", 16'h0010);

    // 4: wrap search from owner 14
    do_reset();
    step(16'h4000, "t4_own14", 16'h4000);
    step(16'h0005, "t4_wrap", 16'h0001);

    // late arrival waits until hold limit is reached
    do_reset();
    step(16'h0001, "t_late_own", 16'h0001);
    for (int k = 0; k < 3; k++) step(16'h0003, "t_late_hold", 16'h0001);
    step(16'h0003, "t_late_preempt", 16'h0002);

    // 5: sole requester never preempted, then release to idle
    do_reset();
    for (int k = 0; k < 20; k++) step(16'h0100, "t5_sole", 16'h0100);
    step(16'h0000, "t5_idle", 16'h0000);

    // 6: reset mid-grant, then priority restarts at index 0
    step(16'h0100, "t6_own8", 16'h0100);
    reset = 1'b1;
    step(16'h0100, "t6_reset", 16'h0000);
    reset = 1'b0;
    step(16'h8001, "t6_restart", 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
